// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit-opcode in-order core.
//   - opcode constants and instruction field positions
//   - NOP_INSTR, the bubble word (opcode 4'b1111, writes nothing)
//   - fetch_state_t, the instruction-fetch FSM state encoding
package cpu_pkg;

  localparam logic [3:0] OP_LW    = 4'h0;
  localparam logic [3:0] OP_SW    = 4'h1;
  localparam logic [3:0] OP_LI    = 4'h2;
  localparam logic [3:0] OP_ADDU  = 4'h3;
  localparam logic [3:0] OP_ADDIU = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_MUL   = 4'h6;
  localparam logic [3:0] OP_BGE   = 4'h7;
  localparam logic [3:0] OP_J     = 4'h8;
  localparam logic [3:0] OP_MULI  = 4'h9;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int RD_MSB     = 27;
  localparam int RD_LSB     = 23;
  localparam int RS_MSB     = 22;
  localparam int RS_LSB     = 18;
  localparam int RT_MSB     = 17;
  localparam int RT_LSB     = 13;

  localparam logic [31:0] NOP_INSTR = 32'hF000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_RESP,
    FETCH_HOLD
  } fetch_state_t;

  function automatic logic [3:0] instr_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: one-entry instruction/PC holding register.
// Catches a fetch response that arrives while IF/ID is frozen.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   clear_i           drop the entry (wins over load)
//   load_i            capture instr_i/pc_i and mark valid
//   instr_i, pc_i     word and its PC
//   valid_o           entry holds a word
//   instr_o, pc_o     held word and its PC
module if_hold_buf #(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                valid_o,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_o
);
  import cpu_pkg::*;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      instr_o <= NOP_INSTR;
      pc_o    <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch plus IF/ID pipeline register.
// Owns the PC, issues single-outstanding word fetches over req/gnt/rvalid,
// and presents the fetched word on ir1_o/pc1_o/valid1_o.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   stall_pc_i                   hold PC, no new fetch
//   stall_ifid_i                 freeze IF/ID
//   redirect_i, redirect_pc_i    taken branch/jump from EX (overrides stalls)
//   imem_req_o, imem_addr_o      fetch request and word address
//   imem_gnt_i                   request accepted
//   imem_rvalid_i, imem_rdata_i  response
//   ir1_o, pc1_o, valid1_o       IF/ID instruction, its PC, real-vs-bubble
// Optional (macro IF_PERF_CNT_EN): fetch_cnt_o, stall_cnt_o, drop_cnt_o,
//   32-bit saturating counters of delivered words, stall_pc cycles and
//   responses discarded by redirect.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// REQ   | request presented at pc, waiting for gnt
// RESP  | request granted, waiting for rvalid (drop set: discard it)
// HOLD  | stall_pc holds off the next request
module if_stage #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_pc_i,
  input  logic                stall_ifid_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  output logic [31:0]         ir1_o,
  output logic [PC_WIDTH-1:0] pc1_o,
  output logic                valid1_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt_o,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         drop_cnt_o
`endif
);
  import cpu_pkg::*;

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  drop_q, drop_d;

  logic                  resp_seen, resp_keep, resp_discard;
  logic                  hold_valid, hold_load, hold_clear;
  logic [31:0]           hold_instr;
  logic [PC_WIDTH-1:0]   hold_pc;
  logic                  ifid_load;

  assign resp_seen    = (state_q == FETCH_RESP) && imem_rvalid_i;
  assign resp_keep    = resp_seen && !drop_q && !redirect_i;
  assign resp_discard = resp_seen && (drop_q || redirect_i);

  // A presented request stays up until granted; stall_pc only keeps the
  // next one from being launched.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) state_d = FETCH_RESP;
      end
      FETCH_RESP: begin
        if (imem_rvalid_i) begin
          drop_d  = 1'b0;
          if (!drop_q) pc_d = pc_q + PC_WIDTH'(1);
          state_d = stall_pc_i ? FETCH_HOLD : FETCH_REQ;
        end
      end
      FETCH_HOLD: if (!stall_pc_i) state_d = FETCH_REQ;
      default:    state_d = FETCH_IDLE;
    endcase
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      // Anything granted but not yet answered must be thrown away.
      if (((state_q == FETCH_RESP) && !imem_rvalid_i) ||
          ((state_q == FETCH_REQ) && imem_gnt_i)) begin
        drop_d  = 1'b1;
        state_d = FETCH_RESP;
      end else begin
        drop_d  = 1'b0;
        state_d = FETCH_REQ;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // IF/ID always takes the oldest waiting word: the held one first, and a
  // response landing in the same cycle refills the buffer.
  assign ifid_load  = !redirect_i && !stall_ifid_i && (hold_valid || resp_keep);
  assign hold_load  = resp_keep && (stall_ifid_i || hold_valid);
  assign hold_clear = redirect_i || (ifid_load && hold_valid && !hold_load);

  if_hold_buf #(.PC_WIDTH(PC_WIDTH)) u_hold_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (hold_clear),
    .load_i  (hold_load),
    .instr_i (imem_rdata_i),
    .pc_i    (pc_q),
    .valid_o (hold_valid),
    .instr_o (hold_instr),
    .pc_o    (hold_pc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir1_o    <= NOP_INSTR;
      pc1_o    <= '0;
      valid1_o <= 1'b0;
    end else if (redirect_i) begin
      ir1_o    <= NOP_INSTR;
      valid1_o <= 1'b0;
    end else if (ifid_load) begin
      ir1_o    <= hold_valid ? hold_instr : imem_rdata_i;
      pc1_o    <= hold_valid ? hold_pc    : pc_q;
      valid1_o <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (ifid_load && (fetch_cnt_o != '1))   fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (stall_pc_i && (stall_cnt_o != '1))  stall_cnt_o <= stall_cnt_o + 32'd1;
      if (resp_discard && (drop_cnt_o != '1)) drop_cnt_o  <= drop_cnt_o + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = resp_discard;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage. The bench acts as the
// instruction memory and keeps a transaction-level model: a queue of
// granted fetches (each flagged if a redirect orphaned it), a queue of
// words waiting for IF/ID, and the next address the PC should request.
module tb_if_stage;
  import cpu_pkg::*;

  localparam int unsigned PW  = 32;
  localparam logic [31:0] NOP = 32'hF000_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_pc_i, stall_ifid_i, redirect_i;
  logic [PW-1:0] redirect_pc_i;
  logic          imem_req_o;
  logic [PW-1:0] imem_addr_o;
  logic          imem_gnt_i, imem_rvalid_i;
  logic [31:0]   imem_rdata_i;
  logic [31:0]   ir1_o;
  logic [PW-1:0] pc1_o;
  logic          valid1_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   fetch_cnt_o, stall_cnt_o, drop_cnt_o;
`endif

  if_stage #(.PC_WIDTH(PW), .RESET_PC('0), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_pc_i    (stall_pc_i),
    .stall_ifid_i  (stall_ifid_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .ir1_o         (ir1_o),
    .pc1_o         (pc1_o),
    .valid1_o      (valid1_o)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o),
    .drop_cnt_o    (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [PW-1:0] addr; logic drop; } pend_t;
  typedef struct { logic [PW-1:0] pc; logic [31:0] instr; } word_t;

  pend_t         pend[$];
  word_t         ready[$];
  logic [31:0]   m_ir;
  logic [PW-1:0] m_pc1, m_next_addr;
  logic          m_valid, m_hold, m_idle, req_exp;
  int            m_fetch, m_stall, m_drop;
  int            n_vec, n_err;

  logic          c_rst, c_stall_pc, c_stall_ifid, c_redirect, c_rdata_en, c_data_rand;
  logic [PW-1:0] c_redir_pc;
  logic [31:0]   c_rdata;
  int            c_gnt_mode, c_rv_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    ready.delete();
    m_ir = NOP; m_pc1 = '0; m_valid = 1'b0;
    m_next_addr = '0; m_hold = 1'b0; m_idle = 1'b1;
    m_fetch = 0; m_stall = 0; m_drop = 0;
  endtask

  task automatic model_step();
    pend_t e;
    word_t w;
    logic  granted;
    m_idle  = 1'b0;
    granted = req_exp && imem_gnt_i;
    if (stall_pc_i) m_stall++;
    if (imem_rvalid_i && pend.size() > 0) begin
      e = pend.pop_front();
      if (e.drop || redirect_i) m_drop++;
      else begin
        m_next_addr = e.addr + 1;
        w.pc = e.addr; w.instr = imem_rdata_i;
        ready.push_back(w);
      end
      m_hold = stall_pc_i;
    end else if (!stall_pc_i) m_hold = 1'b0;
    if (granted) begin
      e.addr = m_next_addr; e.drop = redirect_i;
      pend.push_back(e);
    end
    if (redirect_i) begin
      foreach (pend[i]) pend[i].drop = 1'b1;
      ready.delete();
      m_ir = NOP; m_valid = 1'b0;
      m_next_addr = redirect_pc_i;
      m_hold = 1'b0;
    end else if (!stall_ifid_i && ready.size() > 0) begin
      w = ready.pop_front();
      m_ir = w.instr; m_pc1 = w.pc; m_valid = 1'b1;
      m_fetch++;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    chk("valid1", {31'b0, valid1_o}, {31'b0, m_valid});
    chk("ir1", ir1_o, m_ir);
    if (m_valid) chk("pc1", pc1_o, m_pc1);
    req_exp = !m_idle && !m_hold && (pend.size() == 0);
    chk("req", {31'b0, imem_req_o}, {31'b0, req_exp});
    if (req_exp) chk("addr", imem_addr_o, m_next_addr);

    rst_i         = c_rst;
    stall_pc_i    = c_stall_pc;
    stall_ifid_i  = c_stall_ifid;
    redirect_i    = c_redirect;
    redirect_pc_i = c_redir_pc;
    case (c_gnt_mode)
      0:       imem_gnt_i = imem_req_o && ($urandom_range(0, 2) != 0);
      1:       imem_gnt_i = 1'b0;
      default: imem_gnt_i = imem_req_o;
    endcase
    case (c_rv_mode)
      0:       imem_rvalid_i = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      1:       imem_rvalid_i = 1'b0;
      2:       imem_rvalid_i = (pend.size() > 0);
      default: imem_rvalid_i = 1'b1;
    endcase
    if (c_rdata_en)             imem_rdata_i = c_rdata;
    else if (c_data_rand)       imem_rdata_i = $urandom;
    else if (pend.size() > 0)   imem_rdata_i = pend[0].addr;
    else                        imem_rdata_i = $urandom;
    if (rst_i) model_reset();

    @(posedge clk_i);
    if (!rst_i) model_step();
  endtask

  task automatic wait_pend_addr(input logic [PW-1:0] a, input string tag);
    int budget = 60;
    logic found;
    found = (pend.size() > 0) && (pend[0].addr == a);
    while (!found && budget > 0) begin
      cycle();
      budget--;
      found = (pend.size() > 0) && (pend[0].addr == a);
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic wait_idle_req(input string tag);
    int budget = 60;
    logic found;
    found = (pend.size() == 0) && !m_hold && !m_idle;
    while (!found && budget > 0) begin
      cycle();
      budget--;
      found = (pend.size() == 0) && !m_hold && !m_idle;
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, limit 1ms");
    $fatal(1);
  end

  initial begin
    int si_run;
    n_vec = 0; n_err = 0;
    rst_i = 1'b1; stall_pc_i = 1'b0; stall_ifid_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    c_rst = 1'b1; c_stall_pc = 1'b0; c_stall_ifid = 1'b0; c_redirect = 1'b0;
    c_redir_pc = '0; c_rdata_en = 1'b0; c_data_rand = 1'b0; c_rdata = '0;
    c_gnt_mode = 2; c_rv_mode = 2;
    model_reset();
    req_exp = 1'b0;
    repeat (3) cycle();

    // zero-wait memory, mem[i] = i
    c_rst = 1'b0;
    repeat (8) cycle();

    // stall_pc for 3 cycles as the fetch of 4 completes; resume at 5
    wait_pend_addr(4, "wait_pc4");
    c_stall_pc = 1'b1;
    repeat (3) cycle();
    c_stall_pc = 1'b0;
    repeat (4) cycle();

    // response lands while IF/ID is frozen
    wait_pend_addr(6, "wait_pc6");
    c_rdata_en = 1'b1; c_rdata = 32'h3088_0000; c_stall_ifid = 1'b1;
    cycle();
    c_rdata_en = 1'b0; c_stall_ifid = 1'b0;
    cycle();

    // redirect while the fetch of 7 is outstanding
    c_rv_mode = 1;
    wait_pend_addr(7, "wait_pc7");
    cycle();
    c_redirect = 1'b1; c_redir_pc = 32'h40;
    cycle();
    c_redirect = 1'b0;
    cycle();
    c_rv_mode = 2;
    repeat (6) cycle();

    // grant withheld 4 cycles, redirect on the second
    wait_idle_req("wait_req");
    c_gnt_mode = 1;
    cycle();
    c_redirect = 1'b1; c_redir_pc = 32'h40;
    cycle();
    c_redirect = 1'b0;
    repeat (2) cycle();
    c_gnt_mode = 2;
    repeat (6) cycle();

    // reset in the middle of an outstanding fetch, stale rvalid afterwards
    c_rv_mode = 1;
    wait_idle_req("wait_req2");
    cycle();
    @(negedge clk_i);
    #2;
    rst_i = 1'b1; c_rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ir1", ir1_o, NOP);
    chk("rst_valid", {31'b0, valid1_o}, 32'd0);
    chk("rst_pc1", pc1_o, 32'd0);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    c_rv_mode = 3;
    repeat (2) cycle();
    c_rst = 1'b0;
    cycle();
    c_rv_mode = 2;
    repeat (8) cycle();

    // randomized traffic
    si_run = 0;
    c_data_rand = 1'b1;
    c_gnt_mode = 0; c_rv_mode = 0;
    for (int k = 0; k < 3000; k++) begin
      c_stall_pc = ($urandom_range(0, 3) == 0);
      if (si_run == 0)     c_stall_ifid = (ready.size() == 0) && ($urandom_range(0, 3) == 0);
      else if (si_run < 2) c_stall_ifid = ($urandom_range(0, 1) == 0);
      else                 c_stall_ifid = 1'b0;
      si_run = c_stall_ifid ? si_run + 1 : 0;
      c_redirect = ($urandom_range(0, 19) == 0);
      c_redir_pc = $urandom;
      c_rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    c_rst = 1'b0; c_redirect = 1'b0; c_stall_pc = 1'b0; c_stall_ifid = 1'b0;
    repeat (4) cycle();

`ifdef IF_PERF_CNT_EN
    @(negedge clk_i);
    chk("fetch_cnt", fetch_cnt_o, m_fetch);
    chk("stall_cnt", stall_cnt_o, m_stall);
    chk("drop_cnt", drop_cnt_o, m_drop);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
